// File: rtl/cv32e40s_lsu_response_tracker_if.sv
// Handshake bundle between the LSU request path, the OBI data bus and the
// response tracker.
//   slave  : the tracker's view. It receives the core request, bus ready and
//            bus response, and drives acceptance, core response, imprecise
//            error record and drain status.
//   master : the environment's view, with the directions reversed.
interface cv32e40s_lsu_response_tracker_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              valid_i;
  logic [ADDR_W-1:0] addr_i;
  logic              bufferable_i;
  logic              we_i;
  logic              ready_i;
  logic              valid_o;
  logic              ready_o;
  logic              resp_valid_i;
  logic              resp_err_i;
  logic              resp_valid_o;
  logic              resp_err_o;
  logic              imprecise_err_o;
  logic [ADDR_W-1:0] imprecise_addr_o;
  logic              imprecise_clr_i;
  logic              drain_req_i;
  logic              drained_o;
  logic              busy_o;
  logic              protocol_err_o;

  modport slave (
    input  valid_i, addr_i, bufferable_i, we_i, ready_i,
           resp_valid_i, resp_err_i, imprecise_clr_i, drain_req_i,
    output valid_o, ready_o, resp_valid_o, resp_err_o,
           imprecise_err_o, imprecise_addr_o, drained_o, busy_o, protocol_err_o
  );

  modport master (
    output valid_i, addr_i, bufferable_i, we_i, ready_i,
           resp_valid_i, resp_err_i, imprecise_clr_i, drain_req_i,
    input  valid_o, ready_o, resp_valid_o, resp_err_o,
           imprecise_err_o, imprecise_addr_o, drained_o, busy_o, protocol_err_o
  );
endinterface

// File: rtl/cv32e40s_lsu_response_tracker.sv
// LSU response tracker.
// Keeps a circular queue of outstanding OBI data transfers. Bufferable stores
// (when EARLY_RESP=1) get their core response as soon as they reach the head
// of the core-response order; their bus response is later absorbed, and a bus
// error on one of them is captured as a sticky imprecise error with the
// faulting address. All other transfers forward the bus response to the core
// with zero latency. Core responses are always returned in request order.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   trk        : slave modport of cv32e40s_lsu_response_tracker_if
//                (core request, bus handshake and response, imprecise error
//                 record, drain handshake, busy and protocol-error status)
module cv32e40s_lsu_response_tracker #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter bit          EARLY_RESP = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  cv32e40s_lsu_response_tracker_if.slave trk
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  typedef struct packed {
    logic              early;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t            q [DEPTH];
  logic [PTR_W-1:0]  wp, bp, cp;
  logic [CNT_W-1:0]  bus_cnt, core_cnt;
  logic              imp_err_q;
  logic [ADDR_W-1:0] imp_addr_q;

  entry_t            bus_head, core_head;
  logic              gate, acc, bus_rsp, core_rsp, core_err, imp_evt;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign bus_head  = q[bp];
  assign core_head = q[cp];

  // Acceptance gate only looks at the registered count, so a bus response in
  // the full cycle re-opens the gate on the following cycle.
  assign gate    = (bus_cnt < CNT_MAX) && !trk.drain_req_i;
  assign acc     = trk.valid_i && trk.ready_i && gate;
  assign bus_rsp = trk.resp_valid_i && (bus_cnt != '0);
  assign imp_evt = bus_rsp && bus_head.early && trk.resp_err_i;

  // Core response selection. A non-early head can only be answered when it
  // is also the oldest bus-pending entry; otherwise earlier early stores are
  // still waiting for their (absorbed) bus responses.
  always_comb begin
    core_rsp = 1'b0;
    core_err = 1'b0;
    if (core_cnt != '0) begin
      if (core_head.early) begin
        core_rsp = 1'b1;
      end else if (cp == bp) begin
        core_rsp = trk.resp_valid_i;
        core_err = trk.resp_err_i;
      end
    end
  end

  assign trk.valid_o          = trk.valid_i && gate;
  assign trk.ready_o          = trk.ready_i && gate;
  assign trk.resp_valid_o     = core_rsp;
  assign trk.resp_err_o       = core_err;
  assign trk.imprecise_err_o  = imp_err_q;
  assign trk.imprecise_addr_o = imp_addr_q;
  assign trk.drained_o        = (bus_cnt == '0);
  assign trk.busy_o           = (bus_cnt != '0) || trk.valid_i;
  // A response with nothing outstanding is flagged and otherwise ignored.
  assign trk.protocol_err_o   = trk.resp_valid_i && (bus_cnt == '0);

  // Queue storage: written once at allocation, read at bp and cp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) q[i] <= '0;
    end else if (acc) begin
      q[wp].early <= EARLY_RESP && trk.bufferable_i && trk.we_i;
      q[wp].addr  <= trk.addr_i;
    end
  end

  // Pointers and counters. Each counter moves by up-count minus down-count,
  // so simultaneous allocate/retire leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp       <= '0;
      bp       <= '0;
      cp       <= '0;
      bus_cnt  <= '0;
      core_cnt <= '0;
    end else begin
      if (acc)      wp <= ptr_inc(wp);
      if (bus_rsp)  bp <= ptr_inc(bp);
      if (core_rsp) cp <= ptr_inc(cp);
      bus_cnt  <= bus_cnt  + CNT_W'(acc) - CNT_W'(bus_rsp);
      core_cnt <= core_cnt + CNT_W'(acc) - CNT_W'(core_rsp);
    end
  end

  // Sticky imprecise error. The first address is kept until cleared; a new
  // error arriving together with the clear wins and reloads the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imp_err_q  <= 1'b0;
      imp_addr_q <= '0;
    end else if (imp_evt) begin
      imp_err_q <= 1'b1;
      if (!imp_err_q || trk.imprecise_clr_i) imp_addr_q <= bus_head.addr;
    end else if (trk.imprecise_clr_i) begin
      imp_err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cv32e40s_lsu_response_tracker.sv
// Bench for cv32e40s_lsu_response_tracker. Two instances run side by side:
//   d0: DEPTH=2, EARLY_RESP=1    d1: DEPTH=3, EARLY_RESP=0
// A transaction-level model (per-instance core-order and bus-order queues)
// predicts every output each cycle; expected responses are pushed when a
// request is accepted and popped when the core response appears.
module tb_cv32e40s_lsu_response_tracker;

  typedef struct packed {
    logic [31:0] id;
    logic        early;
    logic [31:0] addr;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cv32e40s_lsu_response_tracker_if #(.ADDR_W(32)) ia ();
  cv32e40s_lsu_response_tracker_if #(.ADDR_W(32)) ib ();

  cv32e40s_lsu_response_tracker #(.DEPTH(2), .ADDR_W(32), .EARLY_RESP(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .trk(ia));
  cv32e40s_lsu_response_tracker #(.DEPTH(3), .ADDR_W(32), .EARLY_RESP(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .trk(ib));

  // Stimulus, indexed by instance.
  logic [1:0]  v, bf, we, rdy, rv, re, clr, dr;
  logic [31:0] a [2];

  assign ia.valid_i = v[0];   assign ib.valid_i = v[1];
  assign ia.addr_i = a[0];    assign ib.addr_i = a[1];
  assign ia.bufferable_i = bf[0]; assign ib.bufferable_i = bf[1];
  assign ia.we_i = we[0];     assign ib.we_i = we[1];
  assign ia.ready_i = rdy[0]; assign ib.ready_i = rdy[1];
  assign ia.resp_valid_i = rv[0]; assign ib.resp_valid_i = rv[1];
  assign ia.resp_err_i = re[0];   assign ib.resp_err_i = re[1];
  assign ia.imprecise_clr_i = clr[0]; assign ib.imprecise_clr_i = clr[1];
  assign ia.drain_req_i = dr[0];  assign ib.drain_req_i = dr[1];

  // Observations, indexed by instance.
  logic [1:0]  o_vld, o_rdy, o_rv, o_re, o_ie, o_drn, o_bsy, o_pe;
  logic [31:0] o_ia [2];
  assign o_vld = {ib.valid_o, ia.valid_o};
  assign o_rdy = {ib.ready_o, ia.ready_o};
  assign o_rv  = {ib.resp_valid_o, ia.resp_valid_o};
  assign o_re  = {ib.resp_err_o, ia.resp_err_o};
  assign o_ie  = {ib.imprecise_err_o, ia.imprecise_err_o};
  assign o_drn = {ib.drained_o, ia.drained_o};
  assign o_bsy = {ib.busy_o, ia.busy_o};
  assign o_pe  = {ib.protocol_err_o, ia.protocol_err_o};
  assign o_ia[0] = ia.imprecise_addr_o;
  assign o_ia[1] = ib.imprecise_addr_o;

  // Model state.
  ent_t        coreq [2][$];
  ent_t        busq  [2][$];
  bit          imp   [2];
  logic [31:0] impa  [2];
  int          nid;
  int          total, bad;

  function automatic int dep(input int d);
    return (d == 0) ? 2 : 3;
  endfunction
  function automatic bit early_en(input int d);
    return d == 0;
  endfunction

  task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL d%0d %s observed=%0h expected=%0h", d, tag, obs, exp);
    end
  endtask

  // One clock: compare all outputs at the falling edge, advance the model,
  // then return just after the rising edge for the next drive.
  task automatic cyc();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      bit gate, acc, brsp, crsp, evt;
      ent_t e;
      if (!rst_n) begin
        coreq[d].delete(); busq[d].delete();
        imp[d] = 1'b0; impa[d] = '0;
      end
      gate = (busq[d].size() < dep(d)) && !dr[d];
      acc  = v[d] && rdy[d] && gate;
      brsp = rv[d] && (busq[d].size() > 0);
      crsp = (coreq[d].size() > 0) &&
             (coreq[d][0].early ||
              (busq[d].size() > 0 && busq[d][0].id == coreq[d][0].id && rv[d]));
      chk(d, "valid_o", o_vld[d], v[d] && gate);
      chk(d, "ready_o", o_rdy[d], rdy[d] && gate);
      chk(d, "resp_valid_o", o_rv[d], crsp);
      if (crsp) chk(d, "resp_err_o", o_re[d], coreq[d][0].early ? 1'b0 : re[d]);
      chk(d, "protocol_err_o", o_pe[d], rv[d] && busq[d].size() == 0);
      chk(d, "drained_o", o_drn[d], busq[d].size() == 0);
      chk(d, "busy_o", o_bsy[d], busq[d].size() != 0 || v[d]);
      chk(d, "imprecise_err_o", o_ie[d], imp[d]);
      chk(d, "imprecise_addr_o", o_ia[d], impa[d]);
      if (rst_n) begin
        if (crsp) void'(coreq[d].pop_front());
        evt = 1'b0;
        if (brsp) begin
          e = busq[d].pop_front();
          evt = e.early && re[d];
        end
        if (evt) begin
          if (!imp[d] || clr[d]) impa[d] = e.addr;
          imp[d] = 1'b1;
        end else if (clr[d]) begin
          imp[d] = 1'b0;
        end
        if (acc) begin
          e.id = nid; nid++;
          e.early = early_en(d) && bf[d] && we[d];
          e.addr = a[d];
          coreq[d].push_back(e);
          busq[d].push_back(e);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d);
    v[d] = 0; bf[d] = 0; we[d] = 0; rv[d] = 0; re[d] = 0; clr[d] = 0; dr[d] = 0; a[d] = '0;
  endtask
  task automatic req(input int d, input logic [31:0] ad, input bit b, input bit w);
    v[d] = 1; a[d] = ad; bf[d] = b; we[d] = w;
  endtask
  task automatic brsp(input int d, input bit vv, input bit err);
    rv[d] = vv; re[d] = err;
  endtask

  initial begin
    total = 0; bad = 0; nid = 0;
    rst_n = 1'b0;
    idle(0); idle(1); rdy = 2'b11;

    // Reset state; ready_o follows ready_i while idle.
    cyc();
    rdy = 2'b00; cyc();
    rdy = 2'b11; rst_n = 1'b1; cyc();

    // d0: three back-to-back bufferable stores, bus delay 3, queue fills.
    req(0, 32'h100, 1, 1); cyc();                        // accept #1
    req(0, 32'h104, 1, 1); cyc();                        // accept #2, early resp #1
    req(0, 32'h108, 1, 1); cyc();                        // full, early resp #2
    brsp(0, 1, 0); cyc();                                // still full, resp #1 absorbed
    brsp(0, 1, 0); cyc();                                // gate reopens: accept #3
    idle(0); brsp(0, 1, 0); cyc();                       // early resp #3, last bus resp
    idle(0); cyc();
    chk(0, "drained_after_burst", o_drn[0], 1'b1);

    // d0: early store ahead of a load; load answered with a bus error.
    req(0, 32'h200, 1, 1); cyc();
    req(0, 32'h204, 0, 0); cyc();
    idle(0); brsp(0, 1, 0); cyc();                       // store resp absorbed
    brsp(0, 1, 1); cyc();                                // load resp forwarded, precise err
    idle(0); cyc();

    // d0: imprecise error capture, first address kept, clear+new error wins.
    req(0, 32'h1000, 1, 1); cyc();
    idle(0); brsp(0, 1, 1); cyc();
    req(0, 32'h2000, 1, 1); cyc();
    idle(0); brsp(0, 1, 1); cyc();
    chk(0, "imp_err_set", o_ie[0], 1'b1);
    chk(0, "imp_addr_first", o_ia[0], 32'h1000);
    req(0, 32'h3000, 1, 1); cyc();
    idle(0); brsp(0, 1, 1); clr[0] = 1; cyc();
    chk(0, "imp_addr_clr_wins", o_ia[0], 32'h3000);
    idle(0); clr[0] = 1; cyc();
    chk(0, "imp_err_cleared", o_ie[0], 1'b0);
    idle(0); cyc();

    // d0: protocol error with nothing outstanding.
    brsp(0, 1, 0); cyc();
    idle(0); cyc();
    chk(0, "perr_one_cycle", o_pe[0], 1'b0);

    // d1 (EARLY_RESP=0): bufferable store waits for its bus response.
    req(1, 32'h40, 1, 1); cyc();
    idle(1); cyc();
    cyc();
    brsp(1, 1, 1); cyc();                                // resp_valid_o + resp_err_o
    idle(1); cyc();

    // d1: drain with two outstanding.
    req(1, 32'h80, 0, 0); cyc();
    req(1, 32'h84, 1, 1); cyc();
    req(1, 32'h88, 1, 1); dr[1] = 1; cyc();              // blocked by drain
    brsp(1, 1, 0); cyc();
    brsp(1, 1, 0); cyc();
    chk(1, "drained_after_last", o_drn[1], 1'b1);
    idle(1); cyc();

    // d1: seven transfers in a row, one-cycle bus latency, pointers wrap.
    for (int i = 0; i < 7; i++) begin
      req(1, 32'h500 + 32'(4 * i), i[0], 1'b1);
      brsp(1, i > 0, i == 4);
      cyc();
    end
    idle(1); brsp(1, 1, 0); cyc();
    idle(1); cyc();

    // Both: random traffic, drain, clear and stray responses included.
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        v[d]   = ($urandom_range(0, 3) != 0);
        a[d]   = $urandom & 32'hfffc;
        bf[d]  = $urandom_range(0, 1);
        we[d]  = $urandom_range(0, 1);
        rdy[d] = ($urandom_range(0, 3) != 0);
        rv[d]  = $urandom_range(0, 1);
        re[d]  = ($urandom_range(0, 3) == 0);
        clr[d] = ($urandom_range(0, 15) == 0);
        dr[d]  = ($urandom_range(0, 7) == 0);
      end
      cyc();
    end

    // Flush everything outstanding, then the scoreboard must be empty.
    idle(0); idle(1); rdy = 2'b11;
    for (int n = 0; n < 8; n++) begin
      rv[0] = busq[0].size() > 0;
      rv[1] = busq[1].size() > 0;
      cyc();
    end
    idle(0); idle(1); cyc();
    chk(0, "sb_empty", coreq[0].size(), 0);
    chk(1, "sb_empty", coreq[1].size(), 0);

    // Mid-operation reset drops outstanding tracking.
    req(0, 32'h900, 1, 1); req(1, 32'h904, 0, 0); cyc();
    idle(0); idle(1); rst_n = 1'b0; cyc();
    rst_n = 1'b1; cyc();
    chk(0, "drained_after_reset", o_drn[0], 1'b1);
    chk(1, "drained_after_reset", o_drn[1], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
